calc_ctrl: RTL
==============

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized button level must hold before it is accepted.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sw  input  8  operand entry switches, two's complement; sampled directly, not synchronized.
REQ-005 op  input  2  operation select: 00 add, 01 sub, 10 and, 11 or.
REQ-006 push  input  1  raw push-button level, active-high (board inversion done upstream); asynchronous to clk.
REQ-007 clr  input  1  synchronous clear request, active-high, already clean.
REQ-008 x  output  8  two's complement value for the downstream 2's-complement display stage.
REQ-009 enable  output  1  display enable for the downstream display stage.
REQ-010 state_o  output  3  current FSM state code, for LEDs.
REQ-011 ovf  output  1  signed overflow of last add/sub.

Function
REQ-012 push SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level db takes the synchronized value only after the synchronized value differs from db for DEBOUNCE_CYCLES consecutive cycles; any return to the db value resets the count to 0.
REQ-013 push_evt (internal) SHALL be a 1-cycle pulse on each db 0->1 transition; db 1->0 produces no event; holding push produces exactly one event.
REQ-014 With push rising before edge t and held, push_evt SHALL be high in cycle t+2+DEBOUNCE_CYCLES.
REQ-015 FSM states/codes: IDLE 000, ENTER_A 001, ENTER_B 010, COMPUTE 011, SHOW 100.
REQ-016 IDLE: push_evt -> ENTER_A.
REQ-017 ENTER_A: push_evt -> capture A<=sw, go ENTER_B.
REQ-018 ENTER_B: push_evt -> capture B<=sw and opr<=op, go COMPUTE.
REQ-019 COMPUTE: lasts exactly 1 cycle; computes R and ovf into registers; go SHOW unconditionally.
REQ-020 SHOW: push_evt -> go ENTER_A; A, B and R are retained until the next capture.
REQ-021 clr=1 in any non-IDLE state SHALL force ENTER_A next cycle and zero A, B, R and ovf; clr has priority over a coincident push_evt; clr in IDLE is ignored.
REQ-022 Arithmetic SHALL be 8-bit with wrap-around:
- add: R=A+B; ovf = (A[7]==B[7]) & (R[7]!=A[7]).
- sub: R=A-B; ovf = (A[7]!=B[7]) & (R[7]!=A[7]).
- and: R=A&B; or: R=A|B; ovf=0 for both.
REQ-023 x, enable and state_o SHALL be registered outputs, reflecting the state entered at the same edge:
- IDLE: x=0, enable=0.
- ENTER_A/ENTER_B: x=sw as sampled at that edge (one-cycle lag), enable=1.
- COMPUTE: x=0, enable=0.
- SHOW: x=R, enable=1.
REQ-024 ovf SHALL update only in COMPUTE or on clr, and hold otherwise.
REQ-025 -128 SHALL be treated as a legal value everywhere; no saturation.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE and clear A, B, opr, R, ovf, x, enable, state_o, the synchronizer flops, db and the debounce counter to 0, from any state including mid-debounce.
REQ-027 reset SHALL have priority over clr and push_evt.
REQ-028 A push held across the deassertion of reset SHALL be debounced from scratch, giving one event DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Debounce: push high 2 cycles, then low -> no push_evt, state stays IDLE; push held 20 cycles -> exactly one push_evt, at t+6.
REQ-030 Add: push to ENTER_A; sw=5 + push; sw=73, op=00 + push -> COMPUTE for 1 cycle (enable=0), then SHOW with x=78, enable=1, ovf=0.
REQ-031 Overflow: A=100, B=100, add -> x=200 mod 256 (-56), ovf=1; A=-128, B=1, sub -> x=127, ovf=1.
REQ-032 Negative result: A=5, B=-128 (0x80)... A=-123 (0x85), B=0, op=11 -> x=0x85, enable=1; the downstream display shows -123.
REQ-033 clr in ENTER_B coincident with push_evt -> next state ENTER_A, A=B=R=0, ovf=0, no capture of B.
REQ-034 reset asserted in SHOW mid-debounce -> next cycle IDLE, x=0, enable=0, state_o=000; no push_evt emitted from the interrupted press.

Source files
------------

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_ctrl
// Brief    : Push-button driven two-operand 8-bit calculator controller with
//            synchronizer/debouncer, capture FSM and registered display outputs.
// Revision : 1.0 - initial release
// ============================================================================
module calc_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic [1:0] op,
    input  logic       push,
    input  logic       clr,
    output logic [7:0] x,
    output logic       enable,
    output logic [2:0] state_o,
    output logic       ovf
);

    localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        ENTER_A = 3'b001,
        ENTER_B = 3'b010,
        COMPUTE = 3'b011,
        SHOW    = 3'b100
    } state_t;

    logic [1:0]      r_sync;
    logic            r_db;
    logic            r_db_d;
    logic            r_evt;
    logic [c_CW-1:0] r_cnt;

    state_t     r_state, w_state_n;
    logic [7:0] r_a, w_a_n;
    logic [7:0] r_b, w_b_n;
    logic [1:0] r_opr, w_opr_n;
    logic [7:0] r_r, w_r_n;
    logic       r_ovf, w_ovf_n;
    logic [7:0] r_x, w_x_n;
    logic       r_en, w_en_n;
    logic [7:0] w_sum, w_dif;

    // Input conditioning; the event is taken one cycle after db rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_evt  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], push};
            if (r_sync[1] != r_db) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_db  <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_db_d <= r_db;
            r_evt  <= r_db & ~r_db_d;
        end
    end

    assign w_sum = r_a + r_b;
    assign w_dif = r_a - r_b;

    always_comb begin
        w_state_n = r_state;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_opr_n   = r_opr;
        w_r_n     = r_r;
        w_ovf_n   = r_ovf;
        if (clr && (r_state != IDLE)) begin
            w_state_n = ENTER_A;
            w_a_n     = 8'd0;
            w_b_n     = 8'd0;
            w_r_n     = 8'd0;
            w_ovf_n   = 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (r_evt) w_state_n = ENTER_A;
                ENTER_A: if (r_evt) begin
                    w_a_n     = sw;
                    w_state_n = ENTER_B;
                end
                ENTER_B: if (r_evt) begin
                    w_b_n     = sw;
                    w_opr_n   = op;
                    w_state_n = COMPUTE;
                end
                COMPUTE: begin
                    w_state_n = SHOW;
                    case (r_opr)
                        2'b00: begin
                            w_r_n   = w_sum;
                            w_ovf_n = (r_a[7] == r_b[7]) & (w_sum[7] != r_a[7]);
                        end
                        2'b01: begin
                            w_r_n   = w_dif;
                            w_ovf_n = (r_a[7] != r_b[7]) & (w_dif[7] != r_a[7]);
                        end
                        2'b10: begin
                            w_r_n   = r_a & r_b;
                            w_ovf_n = 1'b0;
                        end
                        default: begin
                            w_r_n   = r_a | r_b;
                            w_ovf_n = 1'b0;
                        end
                    endcase
                end
                SHOW:    if (r_evt) w_state_n = ENTER_A;
                default: w_state_n = IDLE;
            endcase
        end

        // Display reflects the state being entered at this edge.
        w_x_n  = 8'd0;
        w_en_n = 1'b0;
        case (w_state_n)
            ENTER_A, ENTER_B: begin
                w_x_n  = sw;
                w_en_n = 1'b1;
            end
            SHOW: begin
                w_x_n  = w_r_n;
                w_en_n = 1'b1;
            end
            default: begin
                w_x_n  = 8'd0;
                w_en_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_opr   <= 2'b00;
            r_r     <= 8'd0;
            r_ovf   <= 1'b0;
            r_x     <= 8'd0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_opr   <= w_opr_n;
            r_r     <= w_r_n;
            r_ovf   <= w_ovf_n;
            r_x     <= w_x_n;
            r_en    <= w_en_n;
        end
    end

    assign x       = r_x;
    assign enable  = r_en;
    assign state_o = r_state;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire
